// File: rtl/frogger_pkg.sv
// Shared types, codes and small arithmetic helpers for the Frogger round sequencer.
package frogger_pkg;

    // Game phase; also driven out on the state port for observation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } game_state_t;

    // Winner codes presented on the winner port.
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Score increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Decrements that stop at zero.
    function automatic logic [1:0] dec_floor2(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    function automatic logic [3:0] dec_floor4(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    function automatic logic [7:0] dec_floor8(input logic [7:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

    // Round verdict from the post-update values. Lives are judged first,
    // then the crossing target, then the round timer. WIN_NONE means play on.
    function automatic logic [1:0] judge_round(
        input logic [1:0] l1,
        input logic [1:0] l2,
        input logic [3:0] s1,
        input logic [3:0] s2,
        input logic [7:0] t,
        input logic [3:0] target
    );
        logic [1:0] verdict;
        verdict = WIN_NONE;
        if (l1 == 2'd0 && l2 == 2'd0)          verdict = WIN_DRAW;
        else if (l1 == 2'd0)                   verdict = WIN_P2;
        else if (l2 == 2'd0)                   verdict = WIN_P1;
        else if (s1 >= target && s2 >= target) verdict = WIN_DRAW;
        else if (s1 >= target)                 verdict = WIN_P1;
        else if (s2 >= target)                 verdict = WIN_P2;
        else if (t == 8'd0) begin
            if (s1 > s2)      verdict = WIN_P1;
            else if (s2 > s1) verdict = WIN_P2;
            else              verdict = WIN_DRAW;
        end
        return verdict;
    endfunction

endpackage

// File: rtl/frogger_round_ctrl_rise_detect.sv
// Rising-edge detector: a level held high yields a single one-cycle pulse.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    // Remember last cycle's level so only a 0->1 change produces a pulse.
    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b0;
        else       prev <= in;
    end

    assign pulse = in & ~prev;

endmodule

// File: rtl/frogger_round_ctrl.sv
// Round sequencer for the two-player Frogger board: gates frog enables,
// issues restart pulses, keeps scores, lives and the round timer, and
// declares the winner. Every output comes straight from a register.
module frogger_round_ctrl
    import frogger_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int WIN_SCORE   = 5,
    parameter int ROUND_TICKS = 60,
    parameter int HIT_HOLD    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic       p1_enable,
    output logic       p2_enable,
    output logic       p1_restart,
    output logic       p2_restart,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic [7:0] time_left,
    output logic [1:0] state,
    output logic [1:0] winner
);

    localparam logic [1:0] LIVES_V  = 2'(LIVES);
    localparam logic [3:0] TARGET_V = 4'(WIN_SCORE);
    localparam logic [7:0] TICKS_V  = 8'(ROUND_TICKS);
    localparam logic [3:0] HOLD_V   = 4'(HIT_HOLD);

    logic w1_rise, w2_rise, h1_rise, h2_rise;

    rise_detect u_p1_win (.clock(clock), .reset(reset), .in(p1_win), .pulse(w1_rise));
    rise_detect u_p2_win (.clock(clock), .reset(reset), .in(p2_win), .pulse(w2_rise));
    rise_detect u_p1_hit (.clock(clock), .reset(reset), .in(p1_hit), .pulse(h1_rise));
    rise_detect u_p2_hit (.clock(clock), .reset(reset), .in(p2_hit), .pulse(h2_rise));

    game_state_t state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [3:0]  score1_d, score2_d;
    logic [1:0]  lives1_d, lives2_d;
    logic [7:0]  time_d;
    logic [1:0]  winner_d, verdict;
    logic        ev_w1, ev_w2, ev_h1, ev_h2, any_hit, hold_done, launch;
    logic        enable_d, restart1_d, restart2_d;

    assign state = state_q;

    // Accepted events and next scores, lives, timer and hold count for this cycle.
    always_comb begin
        score1_d  = score1;
        score2_d  = score2;
        lives1_d  = lives1;
        lives2_d  = lives2;
        time_d    = time_left;
        hold_d    = hold_q;
        ev_w1     = 1'b0;
        ev_w2     = 1'b0;
        ev_h1     = 1'b0;
        ev_h2     = 1'b0;
        hold_done = 1'b0;
        verdict   = WIN_NONE;
        launch    = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    launch   = 1'b1;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    lives1_d = LIVES_V;
                    lives2_d = LIVES_V;
                    time_d   = TICKS_V;
                end
            end
            PLAY: begin
                // A crossing wins over a hit on the same frog in the same cycle.
                ev_w1 = w1_rise;
                ev_w2 = w2_rise;
                ev_h1 = h1_rise & ~w1_rise;
                ev_h2 = h2_rise & ~w2_rise;
                if (ev_w1) score1_d = sat_inc4(score1);
                if (ev_w2) score2_d = sat_inc4(score2);
                if (ev_h1) lives1_d = dec_floor2(lives1);
                if (ev_h2) lives2_d = dec_floor2(lives2);
                if (tick)  time_d   = dec_floor8(time_left);
                if (ev_h1 | ev_h2) hold_d = HOLD_V;
                verdict = judge_round(lives1_d, lives2_d, score1_d, score2_d, time_d, TARGET_V);
            end
            HOLD: begin
                if (tick) begin
                    hold_d = dec_floor4(hold_q);
                    time_d = dec_floor8(time_left);
                end
                hold_done = (hold_d == 4'd0);
                verdict   = judge_round(lives1_d, lives2_d, score1_d, score2_d, time_d, TARGET_V);
            end
            default: ;
        endcase
        any_hit = ev_h1 | ev_h2;
    end

    // Next game phase: a decided round always ends in OVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, OVER: if (start) state_d = PLAY;
            PLAY: begin
                if (verdict != WIN_NONE) state_d = OVER;
                else if (any_hit)        state_d = HOLD;
            end
            HOLD: begin
                if (verdict != WIN_NONE) state_d = OVER;
                else if (hold_done)      state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the enable, restart and winner outputs.
    always_comb begin
        enable_d   = (state_d == PLAY);
        restart1_d = launch | ev_w1 | ev_h1;
        restart2_d = launch | ev_w2 | ev_h2;
        winner_d   = winner;
        if (launch)
            winner_d = WIN_NONE;
        else if (state_d == OVER && state_q != OVER)
            winner_d = verdict;
    end

    // Game phase register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            score1     <= 4'd0;
            score2     <= 4'd0;
            lives1     <= LIVES_V;
            lives2     <= LIVES_V;
            time_left  <= TICKS_V;
            hold_q     <= 4'd0;
            winner     <= WIN_NONE;
            p1_enable  <= 1'b0;
            p2_enable  <= 1'b0;
            p1_restart <= 1'b0;
            p2_restart <= 1'b0;
        end else begin
            score1     <= score1_d;
            score2     <= score2_d;
            lives1     <= lives1_d;
            lives2     <= lives2_d;
            time_left  <= time_d;
            hold_q     <= hold_d;
            winner     <= winner_d;
            p1_enable  <= enable_d;
            p2_enable  <= enable_d;
            p1_restart <= restart1_d;
            p2_restart <= restart2_d;
        end
    end

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Directed bench for frogger_round_ctrl. Each step drives one cycle of
// inputs, queues the outputs expected after the next edge, then compares.
// A second instance with a 4-tick round covers timer expiry.
module tb_frogger_round_ctrl;
    import frogger_pkg::*;

    // Input bundle bit order: {start, tick, p1_win, p2_win, p1_hit, p2_hit}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_START = 6'b100000;
    localparam logic [5:0] I_TICK  = 6'b010000;
    localparam logic [5:0] I_W1    = 6'b001000;
    localparam logic [5:0] I_W2    = 6'b000100;
    localparam logic [5:0] I_H1    = 6'b000010;
    localparam logic [5:0] I_H2    = 6'b000001;

    logic clock = 1'b0;
    logic reset, start, tick, p1_win, p2_win, p1_hit, p2_hit;

    logic       a_en1, a_en2, a_rs1, a_rs2;
    logic [3:0] a_s1, a_s2;
    logic [1:0] a_l1, a_l2, a_st, a_win;
    logic [7:0] a_t;

    logic       b_en1, b_en2, b_rs1, b_rs2;
    logic [3:0] b_s1, b_s2;
    logic [1:0] b_l1, b_l2, b_st, b_win;
    logic [7:0] b_t;

    logic [27:0] exp_q[$];
    string       tag_q[$];
    logic        chk_b = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Clock and DUTs
    always #5 clock = ~clock;

    frogger_round_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .p1_win(p1_win), .p2_win(p2_win), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_enable(a_en1), .p2_enable(a_en2), .p1_restart(a_rs1), .p2_restart(a_rs2),
        .score1(a_s1), .score2(a_s2), .lives1(a_l1), .lives2(a_l2),
        .time_left(a_t), .state(a_st), .winner(a_win)
    );

    frogger_round_ctrl #(.ROUND_TICKS(4)) dut_short (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .p1_win(p1_win), .p2_win(p2_win), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_enable(b_en1), .p2_enable(b_en2), .p1_restart(b_rs1), .p2_restart(b_rs2),
        .score1(b_s1), .score2(b_s2), .lives1(b_l1), .lives2(b_l2),
        .time_left(b_t), .state(b_st), .winner(b_win)
    );

    function automatic logic [27:0] pack(
        input logic [1:0] st, win, input logic e1, e2, r1, r2,
        input logic [3:0] s1, s2, input logic [1:0] l1, l2, input logic [7:0] t);
        return {st, win, e1, e2, r1, r2, s1, s2, l1, l2, t};
    endfunction

    function automatic string fmt(input logic [27:0] v);
        return $sformatf("state=%0d winner=%0d en=%b%b restart=%b%b score=%0d/%0d lives=%0d/%0d time=%0d",
                         v[27:26], v[25:24], v[23], v[22], v[21], v[20],
                         v[19:16], v[15:12], v[11:10], v[9:8], v[7:0]);
    endfunction

    // Driver plus scoreboard: drive one cycle, queue expectation, compare after the edge.
    task automatic step(
        input logic [5:0] in,
        input logic [1:0] x_st, x_win, input logic x_en, x_r1, x_r2,
        input logic [3:0] x_s1, x_s2, input logic [1:0] x_l1, x_l2,
        input logic [7:0] x_t, input string tag);
        logic [27:0] obs, exp;
        string       t;
        {start, tick, p1_win, p2_win, p1_hit, p2_hit} = in;
        exp_q.push_back(pack(x_st, x_win, x_en, x_en, x_r1, x_r2, x_s1, x_s2, x_l1, x_l2, x_t));
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        if (chk_b) obs = pack(b_st, b_win, b_en1, b_en2, b_rs1, b_rs2, b_s1, b_s2, b_l1, b_l2, b_t);
        else       obs = pack(a_st, a_win, a_en1, a_en2, a_rs1, a_rs2, a_s1, a_s2, a_l1, a_l2, a_t);
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {%s} expected {%s}", t, fmt(obs), fmt(exp));
    endtask

    initial begin
        reset = 1'b1;
        {start, tick, p1_win, p2_win, p1_hit, p2_hit} = I_NONE;

        // Reset values, tick ignored in IDLE, game start
        step(I_NONE, IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "reset_state");
        step(I_TICK, IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "reset_held");
        reset = 1'b0;
        step(I_TICK,  IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "idle_tick_ignored");
        step(I_START, PLAY, WIN_NONE, 1, 1, 1, 0, 0, 3, 3, 60, "start");
        step(I_NONE,  PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 3, 60, "start_pulse_one_cycle");

        // Held win level counts once; five crossings end the game for P1
        step(I_W1, PLAY, WIN_NONE, 1, 1, 0, 1, 0, 3, 3, 60, "p1_cross1");
        for (int i = 0; i < 9; i++)
            step(I_W1, PLAY, WIN_NONE, 1, 0, 0, 1, 0, 3, 3, 60, "p1_win_held");
        step(I_NONE, PLAY, WIN_NONE, 1, 0, 0, 1, 0, 3, 3, 60, "p1_win_release");
        for (int k = 2; k <= 4; k++) begin
            step(I_W1,   PLAY, WIN_NONE, 1, 1, 0, 4'(k), 0, 3, 3, 60, "p1_cross");
            step(I_NONE, PLAY, WIN_NONE, 1, 0, 0, 4'(k), 0, 3, 3, 60, "p1_cross_release");
        end
        step(I_W1,          OVER, WIN_P1, 0, 1, 0, 5, 0, 3, 3, 60, "p1_reaches_target");
        step(I_NONE,        OVER, WIN_P1, 0, 0, 0, 5, 0, 3, 3, 60, "over_held");
        step(I_TICK | I_W2, OVER, WIN_P1, 0, 0, 0, 5, 0, 3, 3, 60, "over_ignores_tick_win");

        // Hit enters HOLD; wins ignored there; two ticks resume play
        step(I_START, PLAY, WIN_NONE, 1, 1, 1, 0, 0, 3, 3, 60, "restart_from_over");
        step(I_NONE,  PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 3, 60, "restart_settle");
        step(I_H2,    HOLD, WIN_NONE, 0, 0, 1, 0, 0, 3, 2, 60, "p2_hit");
        step(I_NONE,  HOLD, WIN_NONE, 0, 0, 0, 0, 0, 3, 2, 60, "hold_wait");
        step(I_W1,    HOLD, WIN_NONE, 0, 0, 0, 0, 0, 3, 2, 60, "hold_ignores_win");
        step(I_W1 | I_TICK, HOLD, WIN_NONE, 0, 0, 0, 0, 0, 3, 2, 59, "hold_tick1");
        step(I_W1 | I_TICK, PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 2, 58, "hold_tick2_resume");
        step(I_NONE,  PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 2, 58, "held_win_not_scored");

        // Same-frog win+hit: win kept, hit dropped; double hits down to a draw
        step(I_W1 | I_H1, PLAY, WIN_NONE, 1, 1, 0, 1, 0, 3, 2, 58, "win_beats_hit");
        step(I_NONE,      PLAY, WIN_NONE, 1, 0, 0, 1, 0, 3, 2, 58, "win_hit_release");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 1, 0, 3, 2, 57, "play_tick");
        step(I_H1 | I_H2, HOLD, WIN_NONE, 0, 1, 1, 1, 0, 2, 1, 57, "both_hit");
        step(I_NONE,      HOLD, WIN_NONE, 0, 0, 0, 1, 0, 2, 1, 57, "both_hit_hold");
        step(I_TICK,      HOLD, WIN_NONE, 0, 0, 0, 1, 0, 2, 1, 56, "both_hit_tick1");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 1, 0, 2, 1, 55, "both_hit_resume");
        step(I_H1,        HOLD, WIN_NONE, 0, 1, 0, 1, 0, 1, 1, 55, "p1_hit");
        step(I_TICK,      HOLD, WIN_NONE, 0, 0, 0, 1, 0, 1, 1, 54, "p1_hit_tick1");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 1, 0, 1, 1, 53, "p1_hit_resume");
        step(I_H1 | I_H2, OVER, WIN_DRAW, 0, 1, 1, 1, 0, 0, 0, 53, "last_lives_draw");
        step(I_NONE,      OVER, WIN_DRAW, 0, 0, 0, 1, 0, 0, 0, 53, "draw_held");

        // Reset while in HOLD
        step(I_START, PLAY, WIN_NONE, 1, 1, 1, 0, 0, 3, 3, 60, "start_again");
        step(I_NONE,  PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 3, 60, "start_again_settle");
        step(I_H1,    HOLD, WIN_NONE, 0, 1, 0, 0, 0, 2, 3, 60, "hit_before_reset");
        reset = 1'b1;
        step(I_TICK,  IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "reset_in_hold");
        reset = 1'b0;
        step(I_TICK,  IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "post_reset_tick1");
        step(I_TICK,  IDLE, WIN_NONE, 0, 0, 0, 0, 0, 3, 3, 60, "post_reset_tick2");

        // Short round on the 4-tick instance: equal scores at expiry is a draw
        chk_b = 1'b1;
        step(I_START,     PLAY, WIN_NONE, 1, 1, 1, 0, 0, 3, 3, 4, "short_start");
        step(I_NONE,      PLAY, WIN_NONE, 1, 0, 0, 0, 0, 3, 3, 4, "short_settle");
        step(I_W1 | I_W2, PLAY, WIN_NONE, 1, 1, 1, 1, 1, 3, 3, 4, "both_cross1");
        step(I_NONE,      PLAY, WIN_NONE, 1, 0, 0, 1, 1, 3, 3, 4, "both_cross1_release");
        step(I_W1 | I_W2, PLAY, WIN_NONE, 1, 1, 1, 2, 2, 3, 3, 4, "both_cross2");
        step(I_NONE,      PLAY, WIN_NONE, 1, 0, 0, 2, 2, 3, 3, 4, "both_cross2_release");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 2, 2, 3, 3, 3, "short_tick1");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 2, 2, 3, 3, 2, "short_tick2");
        step(I_TICK,      PLAY, WIN_NONE, 1, 0, 0, 2, 2, 3, 3, 1, "short_tick3");
        step(I_TICK,      OVER, WIN_DRAW, 0, 0, 0, 2, 2, 3, 3, 0, "timeout_draw");
        step(I_TICK,      OVER, WIN_DRAW, 0, 0, 0, 2, 2, 3, 3, 0, "time_no_wrap");

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
